// File: rtl/count_run_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : count_run_arbiter
//  Description : Round-robin owner of a shared 3-bit binary/Gray counter.
//                Each grant clears the counter, issues the requested number
//                of advance pulses, waits one settle cycle, then returns the
//                final count with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module count_run_arbiter #(
    parameter int STEP_W = 4,
    parameter int CNT_W  = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic              ModeA,
    input  logic [STEP_W-1:0] StepsA,
    input  logic              ReqB,
    input  logic              ModeB,
    input  logic [STEP_W-1:0] StepsB,
    input  logic [CNT_W-1:0]  CountIn,
    output logic              GntA,
    output logic              GntB,
    output logic              CntClear,
    output logic              CntEn,
    output logic              CntMode,
    output logic              DoneA,
    output logic              DoneB,
    output logic [CNT_W-1:0]  Result,
    output logic              Busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Owner encoding: requester A is 0, requester B is 1.
    localparam logic c_OWN_A = 1'b0;
    localparam logic c_OWN_B = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;     // owner of the most recent grant
    logic                mode_q, mode_d;
    logic [STEP_W-1:0]   remain_q, remain_d;
    logic [CNT_W-1:0]    result_q, result_d;

    logic                w_winner;
    logic                w_owner_req;

    // Winner of arbitration: a lone request wins outright; a tie goes to the
    // requester that was not served last.
    assign w_winner    = (ReqA && ReqB) ? ~last_q : ReqB;
    assign w_owner_req = (owner_q == c_OWN_B) ? ReqB : ReqA;

    // State and datapath registers; the pointer starts as if B was last served.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            owner_q  <= c_OWN_A;
            last_q   <= c_OWN_B;
            mode_q   <= 1'b0;
            remain_q <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            remain_q <= remain_d;
            result_q <= result_d;
        end
    end

    // Next-state logic: arbitration, run sequencing, abort and result capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        mode_d   = mode_q;
        remain_d = remain_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (ReqA || ReqB) begin
                    owner_d  = w_winner;
                    mode_d   = (w_winner == c_OWN_B) ? ModeB : ModeA;
                    remain_d = (w_winner == c_OWN_B) ? StepsB : StepsA;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (!w_owner_req) begin
                    // Owner withdrew: abandon silently but still rotate.
                    state_d  = S_IDLE;
                    last_d   = owner_q;
                    remain_d = '0;
                end else if (remain_q != '0) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_RUN: begin
                if (!w_owner_req) begin
                    state_d  = S_IDLE;
                    last_d   = owner_q;
                    remain_d = '0;
                end else begin
                    remain_d = remain_q - STEP_W'(1);
                    if (remain_q == STEP_W'(1)) begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                // Counter has absorbed the last advance by now.
                result_d = CountIn;
                state_d  = S_DONE;
            end
            S_DONE: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: everything is a function of the registered state.
    always_comb begin
        Busy     = (state_q != S_IDLE);
        GntA     = Busy && (owner_q == c_OWN_A);
        GntB     = Busy && (owner_q == c_OWN_B);
        CntClear = (state_q == S_CLEAR);
        CntEn    = (state_q == S_RUN);
        CntMode  = Busy ? mode_q : 1'b0;
        DoneA    = (state_q == S_DONE) && (owner_q == c_OWN_A);
        DoneB    = (state_q == S_DONE) && (owner_q == c_OWN_B);
        Result   = result_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_count_run_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_run_arbiter
//  Description : Self-checking bench for count_run_arbiter with a behavioural
//                counter stub, a done/result scoreboard and random runs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_run_arbiter;

    localparam int STEP_W = 4;
    localparam int CNT_W  = 3;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              ReqA, ModeA, ReqB, ModeB;
    logic [STEP_W-1:0] StepsA, StepsB;
    logic [CNT_W-1:0]  CountIn;
    logic              GntA, GntB, CntClear, CntEn, CntMode, DoneA, DoneB, Busy;
    logic [CNT_W-1:0]  Result;

    count_run_arbiter #(.STEP_W(STEP_W), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqA(ReqA), .ModeA(ModeA), .StepsA(StepsA),
        .ReqB(ReqB), .ModeB(ModeB), .StepsB(StepsB),
        .CountIn(CountIn),
        .GntA(GntA), .GntB(GntB), .CntClear(CntClear), .CntEn(CntEn),
        .CntMode(CntMode), .DoneA(DoneA), .DoneB(DoneB),
        .Result(Result), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    // ---------------- counter datapath stub ----------------
    logic [CNT_W-1:0] cnt = '0;
    assign CountIn = cnt;

    function automatic logic [2:0] gray_next(input logic [2:0] g);
        logic [2:0] b;
        b[2] = g[2];
        b[1] = g[1] ^ b[2];
        b[0] = g[0] ^ b[1];
        b = b + 3'd1;
        return b ^ (b >> 1);
    endfunction

    always @(posedge Clk) begin
        if (CntClear)   cnt <= '0;
        else if (CntEn) cnt <= CntMode ? gray_next(cnt) : cnt + 3'd1;
    end

    // ---------------- reference model ----------------
    // Final count after S advances from zero: step index S wraps mod 8, and
    // Gray mode reports the reflected code of that index.
    function automatic logic [2:0] exp_result(input logic mode, input logic [3:0] steps);
        int v;
        v = steps % 8;
        if (mode) return 3'(v ^ (v >> 1));
        return 3'(v);
    endfunction

    typedef struct packed {
        logic       who;
        logic [2:0] res;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic last_owner;
    bit   gnt_overlap = 1'b0;
    bit   ce_overlap  = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- monitor ----------------
    always @(negedge Clk) begin
        if (GntA && GntB)     gnt_overlap = 1'b1;
        if (CntClear && CntEn) ce_overlap = 1'b1;
        if (DoneA || DoneB) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_owner", {30'd0, DoneA, DoneB}, mon_e.who ? 1 : 2);
                check("result", int'(Result), int'(mon_e.res));
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic set_req(input logic who, input logic val, input logic mode,
                           input logic [3:0] steps);
        if (who) begin ReqB = val; ModeB = mode; StepsB = steps; end
        else     begin ReqA = val; ModeA = mode; StepsA = steps; end
    endtask

    task automatic drop_req(input logic who);
        if (who) ReqB = 1'b0; else ReqA = 1'b0;
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        last_owner = 1'b1;
    endtask

    task automatic run_single(input logic who, input logic mode, input logic [3:0] steps);
        int cyc, en_cnt, done_cyc;
        bit mode_ok;
        @(negedge Clk);
        set_req(who, 1'b1, mode, steps);
        sb_q.push_back('{who: who, res: exp_result(mode, steps)});
        @(posedge Clk); #1;
        check("grant", who ? int'(GntB) : int'(GntA), 1);
        check("clear", int'(CntClear), 1);
        cyc = 1; en_cnt = 0; done_cyc = -1; mode_ok = 1'b1;
        while (done_cyc < 0 && cyc < 30) begin
            if (CntEn) en_cnt++;
            if (CntMode !== mode) mode_ok = 1'b0;
            if (DoneA || DoneB) done_cyc = cyc;
            else begin @(posedge Clk); #1; cyc++; end
        end
        check("done_time", done_cyc, 3 + int'(steps));
        check("en_cycles", en_cnt, int'(steps));
        check("mode_hold", int'(mode_ok), 1);
        drop_req(who);
        last_owner = who;
        @(posedge Clk); #1;
        check("busy_low", int'(Busy), 0);
    endtask

    task automatic wait_done(input logic who, output int cyc);
        cyc = 0;
        while (!(who ? DoneB : DoneA) && cyc < 40) begin
            @(posedge Clk); #1; cyc++;
        end
    endtask

    task automatic run_pair(input logic ma, input logic [3:0] sa,
                            input logic mb, input logic [3:0] sb);
        logic first, second;
        int   cyc;
        first  = ~last_owner;
        second = last_owner;
        @(negedge Clk);
        set_req(1'b0, 1'b1, ma, sa);
        set_req(1'b1, 1'b1, mb, sb);
        sb_q.push_back('{who: first,  res: first  ? exp_result(mb, sb) : exp_result(ma, sa)});
        sb_q.push_back('{who: second, res: second ? exp_result(mb, sb) : exp_result(ma, sa)});
        @(posedge Clk); #1;
        check("pair_first_grant", first ? int'(GntB) : int'(GntA), 1);
        wait_done(first, cyc);
        check("pair_first_done_seen", first ? int'(DoneB) : int'(DoneA), 1);
        drop_req(first);
        @(posedge Clk); @(posedge Clk); #1;
        check("pair_second_grant", second ? int'(GntB) : int'(GntA), 1);
        wait_done(second, cyc);
        check("pair_second_done_seen", second ? int'(DoneB) : int'(DoneA), 1);
        drop_req(second);
        last_owner = second;
        @(posedge Clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [2:0] prev_res;
        logic       r_who, r_mode, r_mb;
        logic [3:0] r_steps, r_sb;
        Reset = 1'b1;
        ReqA = 1'b0; ModeA = 1'b0; StepsA = '0;
        ReqB = 1'b0; ModeB = 1'b0; StepsB = '0;
        last_owner = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs", {24'd0, GntA, GntB, CntClear, CntEn, CntMode, DoneA, DoneB, Busy}, 0);
        check("reset_result", int'(Result), 0);
        @(negedge Clk);
        Reset = 1'b0;

        // Directed runs
        run_single(1'b0, 1'b0, 4'd5);
        run_single(1'b1, 1'b1, 4'd5);
        run_single(1'b0, 1'b0, 4'd10);
        run_single(1'b0, 1'b0, 4'd0);

        // Simultaneous requests straight after reset: A then B, then A again
        reset_dut();
        run_pair(1'b0, 4'd2, 1'b0, 4'd2);
        run_pair(1'b1, 4'd2, 1'b0, 4'd2);

        // Abort: A withdraws after two RUN cycles of a six-step run
        run_single(1'b1, 1'b1, 4'd3);
        prev_res = Result;
        @(negedge Clk);
        set_req(1'b0, 1'b1, 1'b0, 4'd6);
        @(posedge Clk); #1;   // CLEAR
        @(posedge Clk); #1;   // RUN 1
        @(posedge Clk); #1;   // RUN 2
        ReqA = 1'b0;
        @(posedge Clk); #1;
        check("abort_en_low", int'(CntEn), 0);
        check("abort_idle", int'(Busy), 0);
        repeat (4) @(posedge Clk);
        #1;
        check("abort_result_kept", int'(Result), int'(prev_res));
        last_owner = 1'b0;
        // Pointer moved to A, so B wins the next tie
        run_pair(1'b0, 4'd4, 1'b1, 4'd6);

        // Reset in the middle of a run
        @(negedge Clk);
        set_req(1'b1, 1'b1, 1'b0, 4'd8);
        repeat (3) @(posedge Clk);
        #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        check("midrun_reset_outputs", {24'd0, GntA, GntB, CntClear, CntEn, CntMode, DoneA, DoneB, Busy}, 0);
        check("midrun_reset_result", int'(Result), 0);
        ReqB = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        last_owner = 1'b1;
        repeat (3) @(posedge Clk);

        // Randomised runs
        for (int i = 0; i < 30; i++) begin
            r_who   = 1'($urandom_range(0, 1));
            r_mode  = 1'($urandom_range(0, 1));
            r_steps = 4'($urandom_range(0, 15));
            r_mb    = 1'($urandom_range(0, 1));
            r_sb    = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            if ($urandom_range(0, 2) == 0) run_pair(r_mode, r_steps, r_mb, r_sb);
            else                           run_single(r_who, r_mode, r_steps);
        end

        repeat (4) @(posedge Clk);
        #1;
        check("no_gnt_overlap", int'(gnt_overlap), 0);
        check("no_clear_en_overlap", int'(ce_overlap), 0);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/count_run_arbiter.md
Name: count_run_arbiter

Overview:
- Controller that shares one external 3-bit mode-switchable counter (binary / Gray-style sequence, with clear and advance-enable inputs) between two requesters, A and B.
- Each requester asks for a run of N advance steps in a chosen mode.
- The block arbitrates round-robin, clears the counter, drives the mode and advance pulses, waits one cycle for the count to settle, and returns the final count with a done pulse.
- Sits between the command logic and the counter datapath.

Parameters:
- STEP_W, 4, width of the step-count request fields (max run 2^STEP_W-1 steps)
- CNT_W, 3, width of the counter value returned by the datapath

Ports:
- Clk  in  1  system clock; all logic on rising edge
- Reset  in  1  synchronous, active-high reset
- ReqA  in  1  requester A run request; held high until DoneA
- ModeA  in  1  A run mode: 0 binary, 1 Gray-style sequence
- StepsA  in  STEP_W  A number of advance steps
- ReqB  in  1  requester B run request
- ModeB  in  1  B run mode
- StepsB  in  STEP_W  B number of advance steps
- CountIn  in  CNT_W  current counter value from datapath
- GntA  out  1  A owns the counter
- GntB  out  1  B owns the counter
- CntClear  out  1  one-cycle clear to counter
- CntEn  out  1  advance enable to counter (one step per cycle high)
- CntMode  out  1  latched mode driven to counter
- DoneA  out  1  one-cycle pulse: A run complete, Result valid
- DoneB  out  1  one-cycle pulse: B run complete, Result valid
- Result  out  CNT_W  final count of the last completed run
- Busy  out  1  high in any state other than IDLE

Behaviour:
- The counter datapath samples CntClear/CntEn/CntMode on the same Clk edge; CountIn reflects the update one cycle later.
- Reset (any state, any cycle):
  - State goes to IDLE.
  - All outputs 0, Result=0.
  - Remaining-step counter 0.
  - Round-robin pointer favours A.
  - Mid-run reset aborts silently: no Done pulse.
- State sequence: IDLE -> CLEAR -> RUN -> SETTLE -> DONE -> IDLE.
- IDLE:
  - If any Req is high, pick the winner. Only one request: that one. Both requests: the one not granted last (A after reset).
  - Latch the winner's Mode and Steps, set the winner's Gnt, go to CLEAR.
- CLEAR:
  - CntClear=1, CntMode=latched mode, CntEn=0.
  - Next state RUN if Steps>0, else SETTLE.
- RUN:
  - CntEn=1 every cycle; remaining decrements by 1 per cycle.
  - When remaining==1, next state is SETTLE, so exactly Steps cycles of CntEn are issued.
- SETTLE:
  - CntEn=0.
  - Result <= CountIn at the edge leaving SETTLE.
  - Next state DONE.
- DONE:
  - Done of the owner=1 for exactly one cycle; Gnt stays high.
  - Update the round-robin pointer to the owner.
  - Next state IDLE, Gnt drops.
- Timing for a request sampled in IDLE at cycle n with S>=1:
  - Gnt and CntClear at n+1.
  - CntEn at n+2..n+1+S.
  - SETTLE at n+2+S.
  - Done and Result valid at n+3+S.
  - IDLE at n+4+S.
- Abort: if the owner's Req drops in CLEAR or RUN:
  - CntEn deasserts at the next cycle; state goes to IDLE.
  - No Done pulse; Result unchanged.
  - Pointer still advances to the aborted owner.
- Req/Mode/Steps changes while granted are ignored (latched values only), except for Req deassertion (abort).
- The non-owner's request waits; it is never lost while held high.
- Result holds its value until the next completed run.
- GntA and GntB are never high together; CntClear and CntEn are never high together.
- Wrap-around: the counter wraps naturally; the block does no modulo arithmetic.

Test Plan:
- Reset, then ReqA=1, ModeA=0, StepsA=5 -> GntA one cycle later; CntEn high exactly 5 cycles; DoneA pulse at n+8; Result=3'b101; Busy low at n+9.
- ReqB=1, ModeB=1, StepsB=5 -> counter walks 000,001,011,010,110,111; Result=3'b111; DoneB single pulse; CntMode=1 throughout.
- ReqA=1, StepsA=10, ModeA=0 -> CntEn 10 cycles, Result=3'b010 (wrap); StepsA=0 -> CLEAR then SETTLE, Result=3'b000, DoneA at n+3.
- ReqA and ReqB high together after reset, both StepsA=StepsB=2, both held -> A served first, B granted in the IDLE cycle after DoneA; next simultaneous pair -> A first (B was last owner); no overlapping Gnt.
- ReqA drops after 2 RUN cycles of a 6-step run -> CntEn low next cycle, no DoneA, Result keeps prior value; assert Reset during another RUN -> all outputs 0 the next cycle, no Done.
